fetch_queue: RTL

Parametrised instruction-fetch front end for the ARM pipeline: owns the program counter, reads instruction memory one word per cycle, and buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO in front of decode. Decode consumes entries through a valid/ready handshake. Branch resolution redirects the PC through a one-cycle redirect port that flushes all buffered entries. It replaces the free-running PC register and PC+4 adder with a stall- and flush-aware fetch stage.

---
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue.sv | 69 ++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory port, branch redirect, and decode-side valid/ready head.
// master = fetch_queue side, slave = memory/decode/branch side.
interface fetch_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 3
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_addr, imem_req, out_valid, out_instr, out_pc, count,
        input  imem_instr, redirect_valid, redirect_target, out_ready
    );

    modport slave (
        input  imem_addr, imem_req, out_valid, out_instr, out_pc, count,
        output imem_instr, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// PC owner plus DEPTH-entry {pc, instr} FIFO feeding decode; a fetch is visible to decode after its edge.
// Backpressure: fetch stalls when full unless the head pops that cycle; redirect flushes and costs 2 cycles.
module fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               valid;
    logic               pop;
    logic               push;

    assign valid = (cnt != '0);
    assign pop   = valid & bus.out_ready;
    // A pop frees a slot in the same cycle, so a full queue keeps streaming.
    assign push  = !reset & !bus.redirect_valid & ((cnt < FULL) | pop);

    assign bus.imem_addr = pc;
    assign bus.imem_req  = push;
    assign bus.out_valid = valid;
    assign bus.out_pc    = valid ? pc_mem[rd_ptr]    : '0;
    assign bus.out_instr = valid ? instr_mem[rd_ptr] : '0;
    assign bus.count     = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= {bus.redirect_target[ADDR_W-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_W'(4);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= bus.imem_instr;
        end
    end
endmodule
